// File: rtl/array_index_pkg.sv
// Shared defaults and the index clamp helper for array_index_pipeline.
// Indices wider than IDX_W_MAX bits are not supported by clamp_index.
package array_index_pkg;
  localparam int ELEM_W_DEFAULT    = 33;
  localparam int NUM_ELEMS_DEFAULT = 4;
  localparam int IDX_W_DEFAULT     = 32;
  localparam int IDX_W_MAX         = 64;
  localparam int SEL_W_MAX         = 16;

  // Effective element index: any index at or beyond num_elems collapses onto the last element.
  function automatic logic [SEL_W_MAX-1:0] clamp_index(input logic [IDX_W_MAX-1:0] idx,
                                                       input int unsigned num_elems);
    logic [IDX_W_MAX-1:0] bound_s;
    bound_s = IDX_W_MAX'(num_elems);
    if (idx >= bound_s) begin
      return SEL_W_MAX'(num_elems - 32'd1);
    end else begin
      return idx[SEL_W_MAX-1:0];
    end
  endfunction
endpackage

// File: rtl/array_index_pipe_reg.sv
// One valid/data pipeline stage: loads on load_s, data captured only with a valid beat.
module array_index_pipe_reg #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_s,
  input  logic              valid_s,
  input  logic [DATA_W-1:0] data_s,
  output logic              valid_r,
  output logic [DATA_W-1:0] data_r
);
  // Stage register; data holds across bubbles so an idle input never disturbs it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
    end else if (load_s) begin
      valid_r <= valid_s;
      if (valid_s) begin
        data_r <= data_s;
      end
    end
  end
endmodule

// File: rtl/array_index_pipeline.sv
// Two-stage clamped array reader with valid/ready backpressure.
// Optional out_oob flag port enabled by defining ARRAY_INDEX_OOB_FLAG_EN.
module array_index_pipeline
  import array_index_pkg::*;
#(
  parameter int ELEM_W    = ELEM_W_DEFAULT,
  parameter int NUM_ELEMS = NUM_ELEMS_DEFAULT,
  parameter int IDX_W     = IDX_W_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_ELEMS*ELEM_W-1:0] in_arr,
  input  logic [IDX_W-1:0]            in_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ELEM_W-1:0]           out_elem
`ifdef ARRAY_INDEX_OOB_FLAG_EN
  ,
  output logic                        out_oob
`endif
);
  localparam int ARR_W = NUM_ELEMS * ELEM_W;
  localparam int P0_W  = IDX_W + ARR_W;
  localparam int SEL_W = $clog2(NUM_ELEMS);
`ifdef ARRAY_INDEX_OOB_FLAG_EN
  localparam int P1_W  = ELEM_W + 1;
`else
  localparam int P1_W  = ELEM_W;
`endif

  logic              s0_load_s;
  logic              s1_load_s;
  logic              p0_valid_r;
  logic [P0_W-1:0]   p0_data_r;
  logic [ARR_W-1:0]  p0_arr_r;
  logic [IDX_W-1:0]  p0_idx_r;
  logic [SEL_W-1:0]  sel_s;
  logic [ELEM_W-1:0] sel_elem_s;
  logic [P1_W-1:0]   p1_d_s;
  logic [P1_W-1:0]   p1_data_r;
  logic [ELEM_W-1:0] elem_s [NUM_ELEMS];
  logic [ELEM_W-1:0] term_s [NUM_ELEMS];

  assign s1_load_s = !out_valid || out_ready;
  assign s0_load_s = !p0_valid_r || s1_load_s;
  assign in_ready  = s0_load_s;

  array_index_pipe_reg #(.DATA_W(P0_W)) u_p0 (
    .clk     (clk),
    .rst     (rst),
    .load_s  (s0_load_s),
    .valid_s (in_valid),
    .data_s  ({in_idx, in_arr}),
    .valid_r (p0_valid_r),
    .data_r  (p0_data_r)
  );

  assign p0_arr_r = p0_data_r[ARR_W-1:0];
  assign p0_idx_r = p0_data_r[P0_W-1:ARR_W];

  // Bounds check uses the full-width index, so high index bits always force the clamp.
  assign sel_s = SEL_W'(clamp_index(IDX_W_MAX'(p0_idx_r), NUM_ELEMS));

  for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_elem
    assign elem_s[g] = p0_arr_r[g*ELEM_W +: ELEM_W];
    assign term_s[g] = (sel_s == SEL_W'(g)) ? elem_s[g] : {ELEM_W{1'b0}};
  end

  // OR-reduce the one-hot masked elements into the selected element.
  always_comb begin
    sel_elem_s = {ELEM_W{1'b0}};
    for (int i = 0; i < NUM_ELEMS; i++) begin
      sel_elem_s = sel_elem_s | term_s[i];
    end
  end

`ifdef ARRAY_INDEX_OOB_FLAG_EN
  assign p1_d_s = {(p0_idx_r >= IDX_W'(NUM_ELEMS)), sel_elem_s};
`else
  assign p1_d_s = sel_elem_s;
`endif

  array_index_pipe_reg #(.DATA_W(P1_W)) u_p1 (
    .clk     (clk),
    .rst     (rst),
    .load_s  (s1_load_s),
    .valid_s (p0_valid_r),
    .data_s  (p1_d_s),
    .valid_r (out_valid),
    .data_r  (p1_data_r)
  );

  assign out_elem = p1_data_r[ELEM_W-1:0];
`ifdef ARRAY_INDEX_OOB_FLAG_EN
  assign out_oob  = p1_data_r[ELEM_W];
`endif
endmodule
